// File: rtl/menc_packet_tx_if.sv
// Telemetry-frame transmitter bus: snapshot inputs, start request and serial byte output.
// master = frame source / byte consumer, slave = menc_packet_tx.
interface menc_packet_tx_if;
  logic        start;
  logic [31:0] angle;
  logic [31:0] vel;
  logic [15:0] raw;
  logic [2:0]  halls;
  logic [31:0] temp_celsius;
  logic [7:0]  txd;
  logic        txdv;
  logic        busy;
  logic [31:0] usecs;
  logic [15:0] seq;

  modport master (
    output start, angle, vel, raw, halls, temp_celsius,
    input  txd, txdv, busy, usecs, seq
  );

  modport slave (
    input  start, angle, vel, raw, halls, temp_celsius,
    output txd, txdv, busy, usecs, seq
  );
endinterface

// File: rtl/menc_packet_tx.sv
// Motor-encoder telemetry transmitter: snapshots inputs on start and streams a 48-byte LE frame.
// Define MENC_TX_CHECKSUM_EN to place a 16-bit sum of bytes 0-43 into bytes 44-45.
module menc_packet_tx #(
  parameter int unsigned CLKS_PER_USEC = 100,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic             c,
  input  logic             rst,
  menc_packet_tx_if.slave  bus
);
  localparam int unsigned PW = (CLKS_PER_USEC > 1) ? $clog2(CLKS_PER_USEC) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_USEC - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   usecs_q, usecs_d;
  logic [15:0]   seq_q, seq_d;
  logic [5:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    txd_q, txd_d;
  logic          txdv_q, txdv_d;
  logic          busy_q, busy_d;
  logic [31:0]   angle_q, angle_d, vel_q, vel_d, temp_q, temp_d, usnap_q, usnap_d;
  logic [15:0]   raw_q, raw_d;
  logic [2:0]    halls_q, halls_d;
`ifdef MENC_TX_CHECKSUM_EN
  logic [15:0]   csum_q, csum_d;
`endif
  logic [7:0]    frame_byte;

  always_comb begin
    frame_byte = '0;
    case (idx_q)
      6'd1:  frame_byte = 8'h5A;
      6'd2:  frame_byte = seq_q[7:0];
      6'd3:  frame_byte = seq_q[15:8];
      6'd4:  frame_byte = usnap_q[7:0];
      6'd5:  frame_byte = usnap_q[15:8];
      6'd6:  frame_byte = usnap_q[23:16];
      6'd7:  frame_byte = usnap_q[31:24];
      6'd16: frame_byte = angle_q[7:0];
      6'd17: frame_byte = angle_q[15:8];
      6'd18: frame_byte = angle_q[23:16];
      6'd19: frame_byte = angle_q[31:24];
      6'd20: frame_byte = vel_q[7:0];
      6'd21: frame_byte = vel_q[15:8];
      6'd22: frame_byte = vel_q[23:16];
      6'd23: frame_byte = vel_q[31:24];
      6'd32: frame_byte = raw_q[7:0];
      6'd33: frame_byte = raw_q[15:8];
      6'd36: frame_byte = {5'b0, halls_q};
      6'd40: frame_byte = temp_q[7:0];
      6'd41: frame_byte = temp_q[15:8];
      6'd42: frame_byte = temp_q[23:16];
      6'd43: frame_byte = temp_q[31:24];
`ifdef MENC_TX_CHECKSUM_EN
      6'd44: frame_byte = csum_q[7:0];
      6'd45: frame_byte = csum_q[15:8];
`endif
      default: frame_byte = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q + 1'b1;
    usecs_d = usecs_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    txd_d   = '0;
    txdv_d  = 1'b0;
    busy_d  = busy_q;
    angle_d = angle_q;
    vel_d   = vel_q;
    raw_d   = raw_q;
    halls_d = halls_q;
    temp_d  = temp_q;
    usnap_d = usnap_q;
`ifdef MENC_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      usecs_d = usecs_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          // Byte 0 is a constant, so it goes out on the start edge itself; the index skips ahead.
          angle_d = bus.angle;
          vel_d   = bus.vel;
          raw_d   = bus.raw;
          halls_d = bus.halls;
          temp_d  = bus.temp_celsius;
          usnap_d = usecs_q;
          seq_d   = seq_q + 16'd1;
          txd_d   = 8'hA5;
          txdv_d  = 1'b1;
          busy_d  = 1'b1;
          idx_d   = 6'd1;
`ifdef MENC_TX_CHECKSUM_EN
          csum_d  = 16'h00A5;
`endif
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        busy_d = 1'b1;
        if (idx_q == 6'd48) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          txd_d  = frame_byte;
          txdv_d = 1'b1;
          idx_d  = idx_q + 6'd1;
`ifdef MENC_TX_CHECKSUM_EN
          if (idx_q < 6'd44) csum_d = csum_q + {8'h00, frame_byte};
`endif
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      usecs_q <= '0;
      seq_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      txd_q   <= '0;
      txdv_q  <= 1'b0;
      busy_q  <= 1'b0;
      angle_q <= '0;
      vel_q   <= '0;
      raw_q   <= '0;
      halls_q <= '0;
      temp_q  <= '0;
      usnap_q <= '0;
`ifdef MENC_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      usecs_q <= usecs_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      txdv_q  <= txdv_d;
      busy_q  <= busy_d;
      angle_q <= angle_d;
      vel_q   <= vel_d;
      raw_q   <= raw_d;
      halls_q <= halls_d;
      temp_q  <= temp_d;
      usnap_q <= usnap_d;
`ifdef MENC_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.txd   = txd_q;
  assign bus.txdv  = txdv_q;
  assign bus.busy  = busy_q;
  assign bus.usecs = usecs_q;
  assign bus.seq   = seq_q;
endmodule

// File: tb/tb_menc_packet_tx.sv
// Bench for menc_packet_tx: hand-computed vectors, multi-cycle corner sequences and random frames
// compared against a byte-array frame model built from field positions.
module tb_menc_packet_tx;
  localparam int unsigned CLKS = 4;
  localparam int unsigned GAP  = 4;
`ifdef MENC_TX_CHECKSUM_EN
  localparam logic [15:0] ZERO_SUM = 16'h0100;
`else
  localparam logic [15:0] ZERO_SUM = 16'h0000;
`endif

  typedef logic [7:0] frame_t [48];
  typedef struct {
    logic [31:0] angle, vel;
    logic [15:0] raw;
    logic [2:0]  halls;
    logic [31:0] temp;
    logic [7:0]  e16, e19, e20, e23, e32, e33, e36, e40;
  } vec_t;

  logic c = 1'b0;
  logic rst = 1'b1;
  menc_packet_tx_if bus ();

  menc_packet_tx #(.CLKS_PER_USEC(CLKS), .GAP_CYCLES(GAP)) dut (.c(c), .rst(rst), .bus(bus));

  always #5 c = ~c;

  int unsigned cyc = 0;
  always @(posedge c) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] seq_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t build_frame(input logic [31:0] a, v, input logic [15:0] r,
                                         input logic [2:0] h, input logic [31:0] t,
                                         input logic [31:0] us, input logic [15:0] sq);
    frame_t f;
    logic [15:0] s;
    for (int i = 0; i < 48; i++) f[i] = 8'h00;
    f[0] = 8'hA5;
    f[1] = 8'h5A;
    {f[3], f[2]} = sq;
    {f[7], f[6], f[5], f[4]} = us;
    {f[19], f[18], f[17], f[16]} = a;
    {f[23], f[22], f[21], f[20]} = v;
    {f[33], f[32]} = r;
    f[36] = {5'b0, h};
    {f[43], f[42], f[41], f[40]} = t;
`ifdef MENC_TX_CHECKSUM_EN
    s = '0;
    for (int i = 0; i < 44; i++) s = s + {8'h00, f[i]};
    {f[45], f[44]} = s;
`else
    s = '0;
    {f[45], f[44]} = s;
`endif
    return f;
  endfunction

  task automatic scramble();
    bus.angle        = $urandom;
    bus.vel          = $urandom;
    bus.raw          = 16'($urandom);
    bus.halls        = 3'($urandom);
    bus.temp_celsius = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge c);
    rst = 1'b0;
    seq_m = '0;
  endtask

  // Called at a negedge with the DUT idle; returns once it is idle again.
  task automatic send_frame(input logic [31:0] a, v, input logic [15:0] r, input logic [2:0] h,
                            input logic [31:0] t, input bit repulse, output frame_t got);
    frame_t exp;
    int n, gap, bad_txd;
    logic [31:0] us_exp;
    us_exp = cyc / CLKS;
    chk("usecs_port", bus.usecs, us_exp);
    seq_m = seq_m + 16'd1;
    exp = build_frame(a, v, r, h, t, us_exp, seq_m);
    for (int i = 0; i < 48; i++) got[i] = 8'hXX;
    bus.angle = a; bus.vel = v; bus.raw = r; bus.halls = h; bus.temp_celsius = t;
    bus.start = 1'b1;
    @(negedge c);
    bus.start = 1'b0;
    scramble();
    chk("latency_txdv", {31'b0, bus.txdv}, 32'd1);
    n = 0;
    while (bus.txdv === 1'b1 && n < 64) begin
      if (n < 48) got[n] = bus.txd;
      n++;
      bus.start = repulse && (n == 10);
      @(negedge c);
      scramble();
    end
    bus.start = 1'b0;
    chk("frame_len", n, 48);
    for (int i = 0; i < 48; i++) chk($sformatf("byte%0d", i), {24'b0, got[i]}, {24'b0, exp[i]});
    gap = 0;
    bad_txd = 0;
    while (bus.busy === 1'b1 && bus.txdv === 1'b0 && gap < 32) begin
      if (bus.txd !== 8'h00) bad_txd++;
      bus.start = repulse && (gap == 1);
      gap++;
      @(negedge c);
    end
    bus.start = 1'b0;
    chk("gap_len", gap, GAP);
    chk("gap_txd_zero", bad_txd, 0);
    chk("idle_txdv", {31'b0, bus.txdv}, 32'd0);
    chk("idle_busy", {31'b0, bus.busy}, 32'd0);
    chk("seq_port", {16'b0, bus.seq}, {16'b0, seq_m});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    frame_t got;
    tbl[0] = '{32'h11223344, 32'hAABBCCDD, 16'h1234, 3'b101, 32'h00000019,
               8'h44, 8'h11, 8'hDD, 8'hAA, 8'h34, 8'h12, 8'h05, 8'h19};
    tbl[1] = '{32'h0, 32'h0, 16'h0, 3'b000, 32'h0,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{32'hFFFFFFFF, 32'h80000001, 16'hFFFF, 3'b111, 32'hDEADBEEF,
               8'hFF, 8'hFF, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h07, 8'hEF};
    tbl[3] = '{32'h01020304, 32'h0A0B0C0D, 16'hABCD, 3'b010, 32'h12345678,
               8'h04, 8'h01, 8'h0D, 8'h0A, 8'hCD, 8'hAB, 8'h02, 8'h78};

    bus.start = 1'b0;
    scramble();
    rst = 1'b1;
    repeat (2) @(negedge c);
    chk("rst_txd",   {24'b0, bus.txd}, 32'd0);
    chk("rst_txdv",  {31'b0, bus.txdv}, 32'd0);
    chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
    chk("rst_usecs", bus.usecs, 32'd0);
    chk("rst_seq",   {16'b0, bus.seq}, 32'd0);
    rst = 1'b0;
    seq_m = '0;

    // All-zero frame straight out of reset: usecs=0, seq=1.
    send_frame(32'h0, 32'h0, 16'h0, 3'b000, 32'h0, 1'b0, got);
    chk("zero_b0", {24'b0, got[0]}, 32'hA5);
    chk("zero_b1", {24'b0, got[1]}, 32'h5A);
    chk("zero_b2", {24'b0, got[2]}, 32'h01);
    chk("zero_b3", {24'b0, got[3]}, 32'h00);
    chk("zero_b44", {24'b0, got[44]}, {24'b0, ZERO_SUM[7:0]});
    chk("zero_b45", {24'b0, got[45]}, {24'b0, ZERO_SUM[15:8]});

    // 40 idle cycles after reset at 4 clocks/usec gives a 10 usec snapshot.
    do_reset();
    repeat (40) @(negedge c);
    send_frame(tbl[0].angle, tbl[0].vel, tbl[0].raw, tbl[0].halls, tbl[0].temp, 1'b0, got);
    chk("ts_b4", {24'b0, got[4]}, 32'h0A);
    chk("ts_b5", {24'b0, got[5]}, 32'h00);
    chk("ts_b6", {24'b0, got[6]}, 32'h00);
    chk("ts_b7", {24'b0, got[7]}, 32'h00);
    chk("ts_b2", {24'b0, got[2]}, 32'h01);

    // Back-to-back table frames with start re-pulsed during SEND and GAP.
    for (int k = 0; k < 4; k++) begin
      send_frame(tbl[k].angle, tbl[k].vel, tbl[k].raw, tbl[k].halls, tbl[k].temp, 1'b1, got);
      chk($sformatf("tbl%0d_b16", k), {24'b0, got[16]}, {24'b0, tbl[k].e16});
      chk($sformatf("tbl%0d_b19", k), {24'b0, got[19]}, {24'b0, tbl[k].e19});
      chk($sformatf("tbl%0d_b20", k), {24'b0, got[20]}, {24'b0, tbl[k].e20});
      chk($sformatf("tbl%0d_b23", k), {24'b0, got[23]}, {24'b0, tbl[k].e23});
      chk($sformatf("tbl%0d_b32", k), {24'b0, got[32]}, {24'b0, tbl[k].e32});
      chk($sformatf("tbl%0d_b33", k), {24'b0, got[33]}, {24'b0, tbl[k].e33});
      chk($sformatf("tbl%0d_b36", k), {24'b0, got[36]}, {24'b0, tbl[k].e36});
      chk($sformatf("tbl%0d_b40", k), {24'b0, got[40]}, {24'b0, tbl[k].e40});
      chk($sformatf("tbl%0d_seq", k), {24'b0, got[2]}, 32'(k + 2));
    end

    // start coincident with reset: nothing is sent.
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge c);
    rst = 1'b0;
    bus.start = 1'b0;
    seq_m = '0;
    @(negedge c);
    chk("rststart_txdv", {31'b0, bus.txdv}, 32'd0);
    chk("rststart_busy", {31'b0, bus.busy}, 32'd0);
    chk("rststart_seq",  {16'b0, bus.seq}, 32'd0);

    // Reset while byte 20 is on the wire.
    bus.angle = tbl[0].angle; bus.vel = tbl[0].vel; bus.raw = tbl[0].raw;
    bus.halls = tbl[0].halls; bus.temp_celsius = tbl[0].temp;
    bus.start = 1'b1;
    @(negedge c);
    bus.start = 1'b0;
    repeat (20) @(negedge c);
    chk("midrst_b20", {24'b0, bus.txd}, 32'hDD);
    chk("midrst_txdv_pre", {31'b0, bus.txdv}, 32'd1);
    rst = 1'b1;
    @(negedge c);
    rst = 1'b0;
    seq_m = '0;
    chk("midrst_txdv", {31'b0, bus.txdv}, 32'd0);
    chk("midrst_seq",  {16'b0, bus.seq}, 32'd0);
    chk("midrst_usecs", bus.usecs, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    send_frame(tbl[3].angle, tbl[3].vel, tbl[3].raw, tbl[3].halls, tbl[3].temp, 1'b0, got);
    chk("midrst_next_seq", {24'b0, got[2]}, 32'd1);

    // Random frames with random idle spacing.
    for (int k = 0; k < 8; k++) begin
      int idle;
      idle = int'($urandom_range(0, 9));
      repeat (idle) @(negedge c);
      send_frame($urandom, $urandom, 16'($urandom), 3'($urandom), $urandom,
                 1'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
